// File: rtl/somador_pkg.sv
// Shared types and helpers for the serial adder/subtractor (somador_serial).
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Digit counter width: enough to count WIDTH/DIGIT digits, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
        int unsigned n;
        n = width / digit;
        if (n <= 1) begin
            return 1;
        end
        return 32'($clog2(n));
    endfunction

endpackage

// File: rtl/somador_digito.sv
// DIGIT-bit combinational ripple-carry slice; B arrives already complemented for subtraction.
module somador_digito #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c;

    // Ripple chain of full adders, LSB first.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/somador_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock through one slice.
// Optional zero flag output enabled by defining SOMADOR_SERIAL_ZERO_FLAG_EN.
module somador_serial
    import somador_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);

    // Reject illegal parameter combinations at elaboration.
    if ((WIDTH < 2) || (DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
        $error("somador_serial: WIDTH must be >= 2 and divisible by DIGIT");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dcmsb;
    logic             accept_c;
    logic             last_c;

    somador_digito #(
        .DIGIT (DIGIT)
    ) u_digito (
        .a    (sa[DIGIT-1:0]),
        .b    (sb[DIGIT-1:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    // Next-state decode and start acceptance.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(NDIG - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == IDLE);
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand capture, digit-serial shifting and final flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
            zero     <= 1'b0;
`endif
        end else if (accept_c) begin
            sa    <= a;
            sb    <= (sub == OP_ADD) ? b : ~b;
            carry <= (sub == OP_SUB);
            cnt   <= '0;
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
            zero  <= 1'b0;
`endif
        end else if (state == RUN) begin
            sa     <= sa >> DIGIT;
            sb     <= sb >> DIGIT;
            carry  <= dcout;
            cnt    <= cnt + CW'(1);
            result <= (result >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
            if (last_c) begin
                cout     <= dcout;
                overflow <= dcmsb ^ dcout;
            end
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
            // Accumulates "any bit set"; flipped to a zero flag on the last digit.
            if (last_c) begin
                zero <= ~(zero | (|dsum));
            end else begin
                zero <= zero | (|dsum);
            end
`endif
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: three configurations (8/1, 8/2, 16/4)
// checked every cycle against an arithmetic model plus directed literal checks.
module tb_somador_serial;

    localparam int NI = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [NI];
    logic        sub   [NI];
    logic [15:0] a_in  [NI];
    logic [15:0] b_in  [NI];
    logic        rdy   [NI];
    logic        bsy   [NI];
    logic        dn    [NI];
    logic        co    [NI];
    logic        ov    [NI];
    logic        zf    [NI];
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [15:0] r2;
    logic [15:0] res   [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        res[0] = {8'h00, r0};
        res[1] = {8'h00, r1};
        res[2] = r2;
    end

    somador_serial #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub[0]),
        .a(a_in[0][7:0]), .b(b_in[0][7:0]), .ready(rdy[0]), .busy(bsy[0]),
        .done(dn[0]), .result(r0), .cout(co[0]), .overflow(ov[0])
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
        , .zero(zf[0])
`endif
    );

    somador_serial #(.WIDTH(8), .DIGIT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub[1]),
        .a(a_in[1][7:0]), .b(b_in[1][7:0]), .ready(rdy[1]), .busy(bsy[1]),
        .done(dn[1]), .result(r1), .cout(co[1]), .overflow(ov[1])
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
        , .zero(zf[1])
`endif
    );

    somador_serial #(.WIDTH(16), .DIGIT(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub[2]),
        .a(a_in[2]), .b(b_in[2]), .ready(rdy[2]), .busy(bsy[2]),
        .done(dn[2]), .result(r2), .cout(co[2]), .overflow(ov[2])
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
        , .zero(zf[2])
`endif
    );

`ifndef SOMADOR_SERIAL_ZERO_FLAG_EN
    initial begin
        for (int i = 0; i < NI; i++) zf[i] = 1'b0;
    end
`endif

    function automatic int w_of(input int i);
        return (i == 2) ? 16 : 8;
    endfunction

    function automatic int ndig_of(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    // Reference arithmetic: integer sum/difference, unsigned carry and signed range test.
    function automatic void calc(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic s, output logic [15:0] r, output logic c,
                                 output logic o);
        longint m, ua, ub, sa, sb, t, sum;
        m  = 64'sd1 <<< w;
        ua = longint'(av) & (m - 1);
        ub = longint'(bv) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!s) begin
            sum = ua + ub;
            c   = (sum >= m);
            t   = sa + sb;
        end else begin
            sum = ua - ub + m;
            c   = (ua >= ub);
            t   = sa - sb;
        end
        r = 16'(sum % m);
        o = (t < -(m / 2)) || (t > (m / 2 - 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model state: accepted-op cycle, pending and held results per instance.
    int          cyc = 0;
    bit          act   [NI];
    int          acc   [NI];
    logic [15:0] pend_r[NI];
    logic        pend_c[NI];
    logic        pend_o[NI];
    logic [15:0] held_r[NI];
    logic        held_c[NI];
    logic        held_o[NI];
    logic        held_z[NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            act[i] = 0; acc[i] = 0;
            pend_r[i] = '0; pend_c[i] = 0; pend_o[i] = 0;
            held_r[i] = '0; held_c[i] = 0; held_o[i] = 0; held_z[i] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                act[i] = 0;
                held_r[i] = '0; held_c[i] = 0; held_o[i] = 0; held_z[i] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < NI; i++) begin
                bit idle_m;
                if (act[i] && cyc == acc[i] + ndig_of(i)) begin
                    held_r[i] = pend_r[i];
                    held_c[i] = pend_c[i];
                    held_o[i] = pend_o[i];
                    held_z[i] = (pend_r[i] == 16'h0000);
                end
                idle_m = !act[i] || (cyc - 1 >= acc[i] + ndig_of(i) + 1);
                if (start[i] && idle_m) begin
                    act[i] = 1;
                    acc[i] = cyc;
                    calc(w_of(i), a_in[i], b_in[i], sub[i], pend_r[i], pend_c[i], pend_o[i]);
                end
            end
        end
    end

    // Per-cycle comparison of handshake and held outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                bit run_e, done_e;
                run_e  = act[i] && cyc >= acc[i] && cyc <= acc[i] + ndig_of(i) - 1;
                done_e = act[i] && cyc == acc[i] + ndig_of(i);
                chk($sformatf("u%0d.ready@%0d", i, cyc), 32'(rdy[i]), 32'(!run_e && !done_e));
                chk($sformatf("u%0d.busy@%0d", i, cyc), 32'(bsy[i]), 32'(run_e));
                chk($sformatf("u%0d.done@%0d", i, cyc), 32'(dn[i]), 32'(done_e));
                if (!run_e) begin
                    chk($sformatf("u%0d.result@%0d", i, cyc), 32'(res[i]), 32'(held_r[i]));
                    chk($sformatf("u%0d.cout@%0d", i, cyc), 32'(co[i]), 32'(held_c[i]));
                    chk($sformatf("u%0d.overflow@%0d", i, cyc), 32'(ov[i]), 32'(held_o[i]));
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
                    chk($sformatf("u%0d.zero@%0d", i, cyc), 32'(zf[i]), 32'(held_z[i]));
`endif
                end
            end
        end
    end

    task automatic wait_done(input int i, output int n);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (dn[i]) break;
        end
    endtask

    task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                          input logic s, input logic [15:0] er, input logic ec,
                          input logic eo, input logic ez, input int elat, input string nm);
        int n;
        @(negedge clk);
        a_in[i] = av; b_in[i] = bv; sub[i] = s; start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        n = 1;
        while (!dn[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".latency"}, 32'(n), 32'(elat));
        chk({nm, ".result"}, 32'(res[i]), 32'(er));
        chk({nm, ".cout"}, 32'(co[i]), 32'(ec));
        chk({nm, ".overflow"}, 32'(ov[i]), 32'(eo));
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
        chk({nm, ".zero"}, 32'(zf[i]), 32'(ez));
`else
        if (ez) begin end
`endif
    endtask

    task automatic chk_reset_vals(input int i, input string nm);
        chk({nm, ".ready"}, 32'(rdy[i]), 32'd1);
        chk({nm, ".busy"}, 32'(bsy[i]), 32'd0);
        chk({nm, ".done"}, 32'(dn[i]), 32'd0);
        chk({nm, ".result"}, 32'(res[i]), 32'd0);
        chk({nm, ".cout"}, 32'(co[i]), 32'd0);
        chk({nm, ".overflow"}, 32'(ov[i]), 32'd0);
`ifdef SOMADOR_SERIAL_ZERO_FLAG_EN
        chk({nm, ".zero"}, 32'(zf[i]), 32'd0);
`endif
    endtask

    initial begin
        int n;
        int ndone;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; sub[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals(0, "rst.u0");
        chk_reset_vals(1, "rst.u1");
        chk_reset_vals(2, "rst.u2");

        run_op(0, 16'h35, 16'h4A, 1'b0, 16'h7F, 1'b0, 1'b0, 1'b0, 9, "add35_4a");
        run_op(0, 16'h70, 16'h20, 1'b0, 16'h90, 1'b0, 1'b1, 1'b0, 9, "add70_20");
        run_op(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 9, "addff_01");
        run_op(1, 16'h10, 16'h20, 1'b1, 16'hF0, 1'b0, 1'b0, 1'b0, 5, "sub10_20");
        run_op(1, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0, 5, "sub80_01");
        run_op(1, 16'h00, 16'h00, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1, 5, "sub00_00");
        run_op(2, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 5, "sub1234_1234");
        run_op(2, 16'h1234, 16'h1233, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 5, "sub1234_1233");
        run_op(2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 5, "add7fff_0001");

        // start held high: one done per op, re-accept only after returning to idle.
        @(negedge clk);
        a_in[0] = 16'h0F; b_in[0] = 16'h01; sub[0] = 1'b0; start[0] = 1'b1;
        ndone = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (dn[0]) begin
                ndone++;
                chk("held.result", 32'(res[0]), 32'h10);
            end
        end
        start[0] = 1'b0;
        chk("held.done_count", 32'(ndone), 32'd1);
        wait_done(0, n);
        chk("held.second_done", 32'(dn[0]), 32'd1);
        chk("held.second_result", 32'(res[0]), 32'h10);

        // start pulsed mid-run with other operands is ignored.
        @(negedge clk);
        @(negedge clk);
        a_in[0] = 16'h21; b_in[0] = 16'h12; sub[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_in[0] = 16'hAA; b_in[0] = 16'h55; sub[0] = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, n);
        chk("ignore.latency", 32'(n + 4), 32'd9);
        chk("ignore.result", 32'(res[0]), 32'h33);
        chk("ignore.cout", 32'(co[0]), 32'd0);

        // Reset mid-run: asynchronous clear, no done for the aborted op.
        @(negedge clk);
        a_in[0] = 16'h55; b_in[0] = 16'h0A; sub[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals(0, "midrst.u0");
        chk_reset_vals(2, "midrst.u2");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dn[0]) ndone++;
        end
        chk("midrst.no_done", 32'(ndone), 32'd0);
        chk("midrst.result", 32'(res[0]), 32'd0);
        run_op(0, 16'h55, 16'h0A, 1'b0, 16'h5F, 1'b0, 1'b0, 1'b0, 9, "after_rst");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
